// File: rtl/rf_write_arbiter.sv
// Two one-entry writeback buffers share one registered register-file write port (age, then round-robin).
// Accept-to-port latency 2 cycles; a requester is ready when its buffer is empty or draining this cycle.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iValid0,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [DATA_WIDTH-1:0] iData0,
  output logic                  oReady0,
  input  logic                  iValid1,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oReady1,
  output logic                  oEnWrite,
  output logic [ADDR_WIDTH-1:0] oAddrWrite,
  output logic [DATA_WIDTH-1:0] oDataWrite,
  input  logic [ADDR_WIDTH-1:0] iQueryAddr0,
  input  logic [ADDR_WIDTH-1:0] iQueryAddr1,
  output logic                  oPending0,
  output logic                  oPending1
);

  logic [1:0]            full_q, full_d, age_q, age_d;
  logic [1:0]            grant, ready, load, in_vld;
  logic                  rr_q, rr_d, tie;
  logic [ADDR_WIDTH-1:0] addr_q [2];
  logic [ADDR_WIDTH-1:0] addr_d [2];
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [DATA_WIDTH-1:0] in_data [2];
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  assign in_vld     = {iValid1, iValid0};
  assign in_addr[0] = iAddr0;
  assign in_addr[1] = iAddr1;
  assign in_data[0] = iData0;
  assign in_data[1] = iData1;

  // Age bit set means "accepted strictly before the other full buffer"; equal ages fall back to rr_q.
  always_comb begin
    grant = 2'b00;
    tie   = full_q[0] & full_q[1] & (age_q[0] == age_q[1]);
    if (full_q[0] & full_q[1]) begin
      grant[0] = tie ? ~rr_q : age_q[0];
    end else begin
      grant[0] = full_q[0];
    end
    grant[1] = full_q[1] & ~grant[0];
  end

  // Ready is a function of buffer state only, never of the requester's valid.
  assign ready   = {2{iRst_n}} & (~full_q | grant);
  assign oReady0 = ready[0];
  assign oReady1 = ready[1];

  always_comb begin
    rr_d    = tie ? ~rr_q : rr_q;
    en_d    = |grant;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant[1]) begin
      waddr_d = addr_q[1];
      wdata_d = data_q[1];
    end else if (grant[0]) begin
      waddr_d = addr_q[0];
      wdata_d = data_q[0];
    end
    for (int n = 0; n < 2; n++) begin
      // Writes to register 0 handshake normally but are dropped here.
      load[n]   = in_vld[n] & ready[n] & (in_addr[n] != '0);
      full_d[n] = load[n] | (full_q[n] & ~grant[n]);
      age_d[n]  = ~load[n] & full_q[n] & ~grant[n];
      addr_d[n] = load[n] ? in_addr[n] : addr_q[n];
      data_d[n] = load[n] ? in_data[n] : data_q[n];
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      full_q  <= '0;
      age_q   <= '0;
      rr_q    <= 1'b0;
      en_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      for (int n = 0; n < 2; n++) begin
        addr_q[n] <= '0;
        data_q[n] <= '0;
      end
    end else begin
      full_q  <= full_d;
      age_q   <= age_d;
      rr_q    <= rr_d;
      en_q    <= en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      for (int n = 0; n < 2; n++) begin
        addr_q[n] <= addr_d[n];
        data_q[n] <= data_d[n];
      end
    end
  end

  assign oEnWrite   = en_q;
  assign oAddrWrite = waddr_q;
  assign oDataWrite = wdata_q;

  assign oPending0 = (iQueryAddr0 != '0) &&
                     ((full_q[0] && addr_q[0] == iQueryAddr0) ||
                      (full_q[1] && addr_q[1] == iQueryAddr0) ||
                      (en_q && waddr_q == iQueryAddr0));
  assign oPending1 = (iQueryAddr1 != '0) &&
                     ((full_q[0] && addr_q[0] == iQueryAddr1) ||
                      (full_q[1] && addr_q[1] == iQueryAddr1) ||
                      (en_q && waddr_q == iQueryAddr1));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, random traffic against a sequence-number model,
// and hand sequences for ordering, streaming, zero register and asynchronous reset.
module tb_rf_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          iClk = 1'b0;
  logic          iRst_n = 1'b1;
  logic          iValid0 = 1'b0, iValid1 = 1'b0;
  logic [AW-1:0] iAddr0 = '0, iAddr1 = '0, iQueryAddr0 = '0, iQueryAddr1 = '0;
  logic [DW-1:0] iData0 = '0, iData1 = '0;
  logic          oReady0, oReady1, oEnWrite, oPending0, oPending1;
  logic [AW-1:0] oAddrWrite;
  logic [DW-1:0] oDataWrite;

  always #5 iClk = ~iClk;

  rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iValid0(iValid0), .iAddr0(iAddr0), .iData0(iData0), .oReady0(oReady0),
    .iValid1(iValid1), .iAddr1(iAddr1), .iData1(iData1), .oReady1(oReady1),
    .oEnWrite(oEnWrite), .oAddrWrite(oAddrWrite), .oDataWrite(oDataWrite),
    .iQueryAddr0(iQueryAddr0), .iQueryAddr1(iQueryAddr1),
    .oPending0(oPending0), .oPending1(oPending1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each slot remembers the cycle number it was accepted in.
  logic          mfull [2];
  logic [AW-1:0] mba [2];
  logic [DW-1:0] mbd [2];
  int            mseq [2];
  logic          mrr, men;
  logic [AW-1:0] moa;
  logic [DW-1:0] mod;
  int            mcyc;
  logic [AW+DW-1:0] port_log [$];

  typedef struct {
    logic v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic v1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic [AW-1:0] q0; logic [AW-1:0] q1;
    logic r0; logic r1; logic en; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic p0; logic p1;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      mfull[n] = 1'b0; mba[n] = '0; mbd[n] = '0; mseq[n] = 0;
    end
    mrr = 1'b0; men = 1'b0; moa = '0; mod = '0; mcyc = 0;
  endtask

  function automatic logic [1:0] mgrant();
    if (mfull[0] && mfull[1]) begin
      if (mseq[0] < mseq[1]) return 2'b01;
      if (mseq[1] < mseq[0]) return 2'b10;
      return mrr ? 2'b10 : 2'b01;
    end
    return {mfull[1], mfull[0]};
  endfunction

  function automatic logic mpend(input logic [AW-1:0] q);
    if (q == 0) return 1'b0;
    return (mfull[0] && mba[0] == q) || (mfull[1] && mba[1] == q) || (men && moa == q);
  endfunction

  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic [AW-1:0] q0, input logic [AW-1:0] q1);
    logic [1:0] g;
    logic r0, r1, contend;
    int idx;
    @(negedge iClk);
    iValid0 = v0; iAddr0 = a0; iData0 = d0;
    iValid1 = v1; iAddr1 = a1; iData1 = d1;
    iQueryAddr0 = q0; iQueryAddr1 = q1;
    #1;
    g  = mgrant();
    r0 = iRst_n && (!mfull[0] || g[0]);
    r1 = iRst_n && (!mfull[1] || g[1]);
    chk("ready0", oReady0, r0);
    chk("ready1", oReady1, r1);
    chk("pending0", oPending0, mpend(q0));
    chk("pending1", oPending1, mpend(q1));
    chk("en_write", oEnWrite, men);
    chk("addr_write", oAddrWrite, moa);
    chk("data_write", oDataWrite, mod);
    if (oEnWrite) port_log.push_back({oAddrWrite, oDataWrite});
    if (!iRst_n) begin
      model_reset();
    end else begin
      contend = mfull[0] && mfull[1] && (mseq[0] == mseq[1]);
      if (g != 2'b00) begin
        idx = g[1] ? 1 : 0;
        men = 1'b1; moa = mba[idx]; mod = mbd[idx]; mfull[idx] = 1'b0;
      end else begin
        men = 1'b0;
      end
      if (contend) mrr = ~mrr;
      if (v0 && r0 && a0 != 0) begin mfull[0] = 1'b1; mba[0] = a0; mbd[0] = d0; mseq[0] = mcyc; end
      if (v1 && r1 && a1 != 0) begin mfull[1] = 1'b1; mba[1] = a1; mbd[1] = d1; mseq[1] = mcyc; end
      mcyc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iValid0 = 0; iValid1 = 0; iAddr0 = '0; iAddr1 = '0; iData0 = '0; iData1 = '0;
    iRst_n = 1'b0;
    #1;
    chk("rst_ready0", oReady0, 0);
    chk("rst_en", oEnWrite, 0);
    model_reset();
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
    chk("post_rst_ready0", oReady0, 1);
    chk("post_rst_ready1", oReady1, 1);
  endtask

  function automatic vec_t mk(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic [AW-1:0] q0, input logic [AW-1:0] q1,
                              input logic r0, input logic r1, input logic en,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic p0, input logic p1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.q0 = q0; v.q1 = q1; v.r0 = r0; v.r1 = r1; v.en = en; v.wa = wa; v.wd = wd;
    v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  initial begin
    logic [AW-1:0] order [8];
    int r7_first, r7_second;
    logic [AW+DW-1:0] e;

    // Single write, four equal-age contention rounds, then a register-0 write.
    tbl[0]  = mk(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0,            0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0,            5, 0, 1, 1, 0, 0, 0,            1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,            5, 0, 1, 1, 1, 5, 32'hDEAD_BEEF, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,            5, 0, 1, 1, 0, 0, 0,            0, 0);
    tbl[4]  = mk(1, 3, 1, 1, 4, 2,            3, 0, 1, 1, 0, 0, 0,            0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,            3, 0, 1, 0, 0, 0, 0,            1, 0);
    tbl[6]  = mk(1, 3, 1, 1, 4, 2,            3, 0, 1, 1, 1, 3, 1,            1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,            3, 0, 0, 1, 1, 4, 2,            1, 0);
    tbl[8]  = mk(1, 3, 1, 1, 4, 2,            3, 0, 1, 1, 1, 4, 2,            1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,            3, 0, 1, 0, 1, 3, 1,            1, 0);
    tbl[10] = mk(1, 3, 1, 1, 4, 2,            3, 0, 1, 1, 1, 3, 1,            1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,            3, 0, 0, 1, 1, 4, 2,            1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,            3, 0, 1, 1, 1, 4, 2,            1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,            3, 0, 1, 1, 1, 3, 1,            1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,            3, 0, 1, 1, 0, 0, 0,            0, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 1, 0, 0, 0,           0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 1, 0, 0, 0,            0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0,            0, 0, 1, 1, 0, 0, 0,            0, 0);
    order = '{3, 4, 4, 3, 3, 4, 4, 3};

    model_reset();
    #1 iRst_n = 1'b0;
    #2;
    chk("reset_en", oEnWrite, 0);
    chk("reset_addr", oAddrWrite, 0);
    chk("reset_data", oDataWrite, 0);
    chk("reset_ready0", oReady0, 0);
    chk("reset_ready1", oReady1, 0);
    chk("reset_pending0", oPending0, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
    chk("first_cycle_ready0", oReady0, 1);
    chk("first_cycle_ready1", oReady1, 1);

    port_log.delete();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].q0, tbl[i].q1);
      chk($sformatf("tbl%0d_ready0", i), oReady0, tbl[i].r0);
      chk($sformatf("tbl%0d_ready1", i), oReady1, tbl[i].r1);
      chk($sformatf("tbl%0d_en", i), oEnWrite, tbl[i].en);
      chk($sformatf("tbl%0d_pend0", i), oPending0, tbl[i].p0);
      chk($sformatf("tbl%0d_pend1", i), oPending1, tbl[i].p1);
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_addr", i), oAddrWrite, tbl[i].wa);
        chk($sformatf("tbl%0d_data", i), oDataWrite, tbl[i].wd);
      end
    end
    chk("table_write_count", port_log.size(), 9);
    for (int i = 0; i < 8 && i + 1 < port_log.size(); i++) begin
      e = port_log[i+1];
      chk($sformatf("rr_order%0d", i), e[AW+DW-1:DW], order[i]);
    end

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    idle(3);

    // Streaming from requester 0 alone.
    do_reset();
    port_log.delete();
    for (int i = 0; i < 8; i++) step(1, AW'(1 + i), 32'h1000 + i, 0, 0, 0, 0, 0);
    idle(3);
    chk("stream_count", port_log.size(), 8);
    for (int i = 0; i < 8 && i < port_log.size(); i++) begin
      e = port_log[i];
      chk($sformatf("stream_data%0d", i), e[DW-1:0], 32'h1000 + i);
    end

    // Same-register ordering: R7=A must reach the port before R7=B.
    do_reset();
    port_log.delete();
    step(1, 9, 1, 1, 7, 32'hA, 7, 7);
    step(1, 7, 32'hB, 0, 0, 0, 7, 7);
    idle(4);
    r7_first = -1; r7_second = -1;
    for (int i = 0; i < port_log.size(); i++) begin
      e = port_log[i];
      if (e[AW+DW-1:DW] == 7) begin
        if (r7_first < 0) r7_first = i;
        else if (r7_second < 0) r7_second = i;
      end
    end
    chk("r7_both_issued", (r7_first >= 0) && (r7_second >= 0), 1);
    if (r7_first >= 0 && r7_second >= 0) begin
      e = port_log[r7_first];
      chk("r7_first_data", e[DW-1:0], 32'hA);
      e = port_log[r7_second];
      chk("r7_second_data", e[DW-1:0], 32'hB);
    end

    // Asynchronous reset between edges with both buffers full and a write issuing.
    do_reset();
    step(1, 10, 32'h100, 1, 11, 32'h101, 12, 11);
    step(1, 12, 32'h102, 1, 13, 32'h103, 12, 11);
    @(posedge iClk);
    #2;
    chk("pre_rst_en", oEnWrite, men);
    chk("pre_rst_pend1", oPending1, mpend(11));
    iRst_n = 1'b0;
    #1;
    chk("midrst_en", oEnWrite, 0);
    chk("midrst_addr", oAddrWrite, 0);
    chk("midrst_data", oDataWrite, 0);
    chk("midrst_ready0", oReady0, 0);
    chk("midrst_ready1", oReady1, 0);
    chk("midrst_pend0", oPending0, 0);
    chk("midrst_pend1", oPending1, 0);
    model_reset();
    iValid0 = 0; iValid1 = 0;
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    port_log.delete();
    idle(5);
    chk("no_stale_write", port_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
